// File: rtl/lsu_axi_master.sv
// Single-beat AXI master for a core load/store unit: one outstanding access,
// byte-lane alignment of load/store data, misalignment rejection without bus traffic.
module lsu_axi_master #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  // core side
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   mem_visit_addr,
  input  logic [1:0]          op_width,
  input  logic [DATA_W-1:0]   mem_write_data,
  output logic [DATA_W-1:0]   mem_read_data,
  output logic                mem_visit_end,
  output logic                mem_err,
  // AXI write address
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  // AXI write data
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  // AXI write response
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  // AXI read address
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  // AXI read data
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RELEASE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_wdata_raw;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_visit_end;
  logic                r_err;

  logic                w_misaligned;
  logic [5:0]          w_shift;
  logic [DATA_W-1:0]   w_size_mask;
  logic [DATA_W-1:0]   w_rdata_aligned;
  logic                w_aw_done;
  logic                w_w_done;
  logic [3:0]          w_strb_lo;
  logic [3:0]          w_strb_hi;
  logic [STRB_W-1:0]   w_strb;

  // Alignment is judged on the live request so a bad access never reaches the bus.
  always_comb begin
    case (op_width)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = mem_visit_addr[0];
      2'd2:    w_misaligned = |mem_visit_addr[1:0];
      default: w_misaligned = |mem_visit_addr[2:0];
    endcase
  end

  always_comb begin
    case (r_op)
      2'd0:    w_size_mask = DATA_W'(8'hFF);
      2'd1:    w_size_mask = DATA_W'(16'hFFFF);
      2'd2:    w_size_mask = DATA_W'(32'hFFFF_FFFF);
      default: w_size_mask = {DATA_W{1'b1}};
    endcase
  end

  assign w_shift         = {r_addr[2:0], 3'b000};
  assign w_rdata_aligned = (rdata >> w_shift) & w_size_mask;

  // A channel counts as done if it was accepted earlier or is being accepted now.
  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid  || wready;

  // Byte lane gi is enabled when it lies in [addr, addr + 2^op_width).
  assign w_strb_lo = {1'b0, r_addr[2:0]};
  assign w_strb_hi = w_strb_lo + (4'd1 << r_op);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign w_strb[gi] = (4'(gi) >= w_strb_lo) && (4'(gi) < w_strb_hi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_op        <= 2'd0;
      r_wdata_raw <= '0;
      r_rdata     <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_visit_end <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_visit_end <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_read || mem_write) begin
            r_addr <= mem_visit_addr;
            r_op   <= op_width;
            if (!mem_read) begin
              r_wdata_raw <= mem_write_data;
            end
            if (w_misaligned) begin
              r_visit_end <= 1'b1;
              r_err       <= 1'b1;
              r_state     <= RELEASE;
            end else if (mem_read) begin
              r_arvalid <= 1'b1;
              r_state   <= RD_ADDR;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_rdata     <= w_rdata_aligned;
            r_err       <= |rresp;
            r_visit_end <= 1'b1;
            r_state     <= RELEASE;
          end
        end
        WR_REQ: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_err       <= |bresp;
            r_visit_end <= 1'b1;
            r_state     <= RELEASE;
          end
        end
        RELEASE: begin
          // Wait for the core to drop its level request so it is not relaunched.
          if (!mem_read && !mem_write) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read_data = r_rdata;
  assign mem_visit_end = r_visit_end;
  assign mem_err       = r_err;

  assign awvalid = r_awvalid;
  assign awaddr  = r_addr;
  assign awsize  = {1'b0, r_op};
  assign awlen   = 8'd0;
  assign awburst = 2'b01;

  assign wvalid  = r_wvalid;
  assign wdata   = r_wdata_raw << w_shift;
  assign wstrb   = w_strb;
  assign wlast   = 1'b1;

  assign bready  = r_bready;

  assign arvalid = r_arvalid;
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_op};
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

  assign rready  = r_rready;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: the slave side is driven cycle by cycle
// from the test tasks with hand-computed expectations.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [63:0] mem_visit_addr;
  logic [1:0]  op_width;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
  logic        mem_visit_end, mem_err;
  logic        awvalid, awready;
  logic [63:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  int checks = 0;
  int failures = 0;
  int ar_cycles = 0;
  int aw_cycles = 0;
  int w_cycles = 0;
  int end_pulses = 0;

  lsu_axi_master #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_visit_addr(mem_visit_addr), .op_width(op_width),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_visit_end(mem_visit_end), .mem_err(mem_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  // Activity counters sampled mid-cycle; tests compare before/after snapshots.
  always @(negedge clk) begin
    if (arvalid)       ar_cycles  <= ar_cycles + 1;
    if (awvalid)       aw_cycles  <= aw_cycles + 1;
    if (wvalid)        w_cycles   <= w_cycles + 1;
    if (mem_visit_end) end_pulses <= end_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (mem_visit_end) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    mem_visit_addr = '0; op_width = 2'd0; mem_write_data = '0;
    slave_idle();
    repeat (3) tick();
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, mem_visit_end, mem_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {arvalid, awvalid, wvalid, rready, bready, mem_visit_end, mem_err});
    end
    checks++;
    if (mem_read_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected 0", mem_read_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, mem_visit_end} !== 6'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got %b expected 000000",
               {arvalid, awvalid, wvalid, rready, bready, mem_visit_end});
    end
    checks++;
    if ({wlast, awlen, arlen, awburst, arburst} !== {1'b1, 8'd0, 8'd0, 2'b01, 2'b01}) begin
      failures++;
      $display("FAIL axi_constants: got %h expected %h",
               {wlast, awlen, arlen, awburst, arburst}, {1'b1, 8'd0, 8'd0, 2'b01, 2'b01});
    end
    $display("txn reset done");
  endtask

  task automatic test_load();
    int e0, a0;
    slave_idle();
    arready = 1'b1; rvalid = 1'b1; rdata = 64'h1234_5678_9ABC_DEF0;
    e0 = end_pulses; a0 = ar_cycles;
    mem_visit_addr = 64'h8000_0006; op_width = 2'd1; mem_read = 1'b1;
    tick();
    checks++;
    if ({arvalid, araddr, arsize, mem_visit_end} !== {1'b1, 64'h8000_0006, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL load_ar: got v=%b a=%h s=%0d end=%b expected v=1 a=80000006 s=1 end=0",
               arvalid, araddr, arsize, mem_visit_end);
    end
    tick();
    checks++;
    if ({arvalid, rready, mem_visit_end} !== 3'b010) begin
      failures++;
      $display("FAIL load_rdata_phase: got ar=%b rr=%b end=%b expected ar=0 rr=1 end=0",
               arvalid, rready, mem_visit_end);
    end
    tick();
    checks++;
    if ({mem_visit_end, mem_err} !== 2'b10) begin
      failures++;
      $display("FAIL load_end: got end=%b err=%b expected end=1 err=0", mem_visit_end, mem_err);
    end
    checks++;
    if (mem_read_data !== 64'h1234) begin
      failures++;
      $display("FAIL load_data: got %h expected 0000000000001234", mem_read_data);
    end
    release_req();
    checks++;
    if ({mem_visit_end, rready} !== 2'b00 || mem_read_data !== 64'h1234) begin
      failures++;
      $display("FAIL load_hold: got end=%b rr=%b data=%h expected end=0 rr=0 data=1234",
               mem_visit_end, rready, mem_read_data);
    end
    checks++;
    if (end_pulses - e0 !== 1 || ar_cycles - a0 !== 1) begin
      failures++;
      $display("FAIL load_counts: got ends=%0d ar=%0d expected ends=1 ar=1",
               end_pulses - e0, ar_cycles - a0);
    end
    $display("txn load addr=80000006 data=%h", mem_read_data);
  endtask

  task automatic test_store();
    slave_idle();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    mem_visit_addr = 64'h8000_0003; op_width = 2'd0; mem_write_data = 64'hAB; mem_write = 1'b1;
    tick();
    checks++;
    if ({awvalid, wvalid, awaddr, awsize} !== {2'b11, 64'h8000_0003, 3'd0}) begin
      failures++;
      $display("FAIL store_aw: got aw=%b w=%b a=%h s=%0d expected aw=1 w=1 a=80000003 s=0",
               awvalid, wvalid, awaddr, awsize);
    end
    checks++;
    if (wstrb !== 8'h08 || wdata !== 64'h0000_0000_AB00_0000) begin
      failures++;
      $display("FAIL store_w: got strb=%h data=%h expected strb=08 data=00000000ab000000",
               wstrb, wdata);
    end
    tick();
    checks++;
    if ({awvalid, wvalid, bready, mem_visit_end} !== 4'b0010) begin
      failures++;
      $display("FAIL store_b_phase: got %b expected 0010", {awvalid, wvalid, bready, mem_visit_end});
    end
    tick();
    checks++;
    if ({mem_visit_end, mem_err, bready} !== 3'b100) begin
      failures++;
      $display("FAIL store_end: got end=%b err=%b br=%b expected 1 0 0", mem_visit_end, mem_err, bready);
    end
    checks++;
    if (mem_read_data !== 64'h1234) begin
      failures++;
      $display("FAIL store_keeps_rdata: got %h expected 1234", mem_read_data);
    end
    release_req();
    $display("txn store addr=80000003 strb=08");
  endtask

  task automatic test_aw_w_skew();
    int e0, a0, w0, lat;
    slave_idle();
    wready = 1'b1; bvalid = 1'b1;
    e0 = end_pulses; a0 = aw_cycles; w0 = w_cycles;
    mem_visit_addr = 64'h8000_0010; op_width = 2'd3;
    mem_write_data = 64'h1122_3344_5566_7788; mem_write = 1'b1;
    tick();
    checks++;
    if ({awvalid, wvalid, wstrb} !== {2'b11, 8'hFF} || wdata !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL skew_start: got aw=%b w=%b strb=%h data=%h expected 1 1 ff 1122334455667788",
               awvalid, wvalid, wstrb, wdata);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 64'h8000_0010) begin
        failures++;
        $display("FAIL skew_hold%0d: got aw=%b w=%b br=%b a=%h expected 1 0 0 80000010",
                 k, awvalid, wvalid, bready, awaddr);
      end
    end
    awready = 1'b1;
    tick();
    checks++;
    if ({awvalid, bready, mem_visit_end} !== 3'b010) begin
      failures++;
      $display("FAIL skew_aw_accept: got aw=%b br=%b end=%b expected 0 1 0", awvalid, bready, mem_visit_end);
    end
    wait_end(5, lat);
    checks++;
    if (lat !== 1 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL skew_end: got lat=%0d err=%b expected lat=1 err=0", lat, mem_err);
    end
    release_req();
    checks++;
    if (end_pulses - e0 !== 1 || aw_cycles - a0 !== 4 || w_cycles - w0 !== 1) begin
      failures++;
      $display("FAIL skew_counts: got ends=%0d aw=%0d w=%0d expected 1 4 1",
               end_pulses - e0, aw_cycles - a0, w_cycles - w0);
    end
    $display("txn skewed store addr=80000010");
  endtask

  task automatic test_misaligned();
    int e0, a0, w0;
    slave_idle();
    arready = 1'b1; rvalid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    e0 = end_pulses; a0 = ar_cycles; w0 = aw_cycles;
    mem_visit_addr = 64'h8000_0002; op_width = 2'd2; mem_read = 1'b1;
    tick();
    checks++;
    if ({mem_visit_end, mem_err, arvalid} !== 3'b110) begin
      failures++;
      $display("FAIL misalign_rd_end: got end=%b err=%b ar=%b expected 1 1 0", mem_visit_end, mem_err, arvalid);
    end
    repeat (2) tick();
    checks++;
    if ({mem_visit_end, arvalid} !== 2'b00) begin
      failures++;
      $display("FAIL misalign_rd_release: got end=%b ar=%b expected 0 0", mem_visit_end, arvalid);
    end
    release_req();
    checks++;
    if (mem_read_data !== 64'h1234) begin
      failures++;
      $display("FAIL misalign_rdata_hold: got %h expected 1234", mem_read_data);
    end
    $display("txn misaligned load addr=80000002");
    mem_visit_addr = 64'h8000_000C; op_width = 2'd3; mem_write = 1'b1;
    tick();
    checks++;
    if ({mem_visit_end, mem_err, awvalid, wvalid} !== 4'b1100) begin
      failures++;
      $display("FAIL misalign_wr_end: got %b expected 1100", {mem_visit_end, mem_err, awvalid, wvalid});
    end
    release_req();
    checks++;
    if (ar_cycles - a0 !== 0 || aw_cycles - w0 !== 0 || end_pulses - e0 !== 2) begin
      failures++;
      $display("FAIL misalign_counts: got ar=%0d aw=%0d ends=%0d expected 0 0 2",
               ar_cycles - a0, aw_cycles - w0, end_pulses - e0);
    end
    $display("txn misaligned store addr=8000000c");
  endtask

  task automatic test_bresp_error_held();
    int e0, a0, lat;
    slave_idle();
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
    e0 = end_pulses; a0 = aw_cycles;
    mem_visit_addr = 64'h8000_0004; op_width = 2'd2;
    mem_write_data = 64'hDEAD_BEEF; mem_write = 1'b1;
    wait_end(10, lat);
    checks++;
    if (lat !== 3 || mem_err !== 1'b1) begin
      failures++;
      $display("FAIL bresp_err: got lat=%0d err=%b expected lat=3 err=1", lat, mem_err);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({mem_visit_end, awvalid, wvalid} !== 3'b000) begin
        failures++;
        $display("FAIL held_write%0d: got end=%b aw=%b w=%b expected 0 0 0",
                 k, mem_visit_end, awvalid, wvalid);
      end
    end
    release_req();
    checks++;
    if (end_pulses - e0 !== 1 || aw_cycles - a0 !== 1) begin
      failures++;
      $display("FAIL held_counts: got ends=%0d aw=%0d expected 1 1", end_pulses - e0, aw_cycles - a0);
    end
    $display("txn store error bresp=10");
  endtask

  task automatic test_reset_mid_read();
    int e0, lat;
    slave_idle();
    arready = 1'b1;
    e0 = end_pulses;
    mem_visit_addr = 64'h8000_0008; op_width = 2'd3; mem_read = 1'b1;
    tick();
    tick();
    checks++;
    if ({arvalid, rready} !== 2'b01) begin
      failures++;
      $display("FAIL rst_pre: got ar=%b rr=%b expected 0 1", arvalid, rready);
    end
    reset = 1'b1; mem_read = 1'b0;
    tick();
    checks++;
    if ({arvalid, rready, mem_visit_end} !== 3'b000 || mem_read_data !== 64'h0) begin
      failures++;
      $display("FAIL rst_abandon: got ar=%b rr=%b end=%b data=%h expected 0 0 0 0",
               arvalid, rready, mem_visit_end, mem_read_data);
    end
    reset = 1'b0;
    tick();
    rvalid = 1'b1; rdata = 64'hCAFE_F00D_1234_5678;
    mem_read = 1'b1;
    wait_end(10, lat);
    checks++;
    if (lat !== 3 || mem_read_data !== 64'hCAFE_F00D_1234_5678 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_fresh_load: got lat=%0d data=%h err=%b expected 3 cafef00d12345678 0",
               lat, mem_read_data, mem_err);
    end
    release_req();
    checks++;
    if (end_pulses - e0 !== 1) begin
      failures++;
      $display("FAIL rst_counts: got ends=%0d expected 1", end_pulses - e0);
    end
    $display("txn load after reset data=%h", mem_read_data);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ld_addr [4] = '{64'h8000_0005, 64'h8000_0004, 64'h8000_0002, 64'h8000_0000};
    logic [1:0]  ld_op   [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
    logic [1:0]  ld_resp [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
    logic [63:0] ld_exp  [4] = '{64'h33, 64'h1122_3344, 64'h5566, 64'h1122_3344_5566_7788};
    logic [63:0] st_addr [2] = '{64'h8000_0006, 64'h8000_0004};
    logic [1:0]  st_op   [2] = '{2'd1, 2'd2};
    logic [63:0] st_data [2] = '{64'hBEEF, 64'h0102_0304};
    logic [7:0]  st_strb [2] = '{8'hC0, 8'hF0};
    logic [63:0] st_wdat [2] = '{64'hBEEF_0000_0000_0000, 64'h0102_0304_0000_0000};
    int lat;
    slave_idle();
    arready = 1'b1; rvalid = 1'b1; rdata = 64'h1122_3344_5566_7788;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rresp = ld_resp[i];
      mem_visit_addr = ld_addr[i]; op_width = ld_op[i]; mem_read = 1'b1;
      wait_end(10, lat);
      checks++;
      if (lat !== 3 || mem_read_data !== ld_exp[i] || mem_err !== (ld_resp[i] != 2'b00)) begin
        failures++;
        $display("FAIL b2b_load%0d: got lat=%0d data=%h err=%b expected lat=3 data=%h err=%b",
                 i, lat, mem_read_data, mem_err, ld_exp[i], ld_resp[i] != 2'b00);
      end
      $display("txn load addr=%h op=%0d data=%h err=%b", ld_addr[i], ld_op[i], mem_read_data, mem_err);
      release_req();
    end
    rresp = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mem_visit_addr = st_addr[i]; op_width = st_op[i]; mem_write_data = st_data[i]; mem_write = 1'b1;
      tick();
      checks++;
      if (wstrb !== st_strb[i] || wdata !== st_wdat[i] || awsize !== {1'b0, st_op[i]}) begin
        failures++;
        $display("FAIL b2b_store%0d: got strb=%h data=%h size=%0d expected strb=%h data=%h size=%0d",
                 i, wstrb, wdata, awsize, st_strb[i], st_wdat[i], st_op[i]);
      end
      wait_end(10, lat);
      checks++;
      if (lat !== 2 || mem_err !== 1'b0) begin
        failures++;
        $display("FAIL b2b_store_end%0d: got lat=%0d err=%b expected 2 0", i, lat, mem_err);
      end
      $display("txn store addr=%h strb=%h", st_addr[i], wstrb);
      release_req();
    end
    // Simultaneous load and store requests: the load must win.
    mem_visit_addr = 64'h8000_0020; op_width = 2'd3;
    mem_read = 1'b1; mem_write = 1'b1;
    tick();
    checks++;
    if ({arvalid, awvalid, wvalid} !== 3'b100) begin
      failures++;
      $display("FAIL read_priority: got ar=%b aw=%b w=%b expected 1 0 0", arvalid, awvalid, wvalid);
    end
    wait_end(10, lat);
    checks++;
    if (lat !== 2 || mem_read_data !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL read_priority_end: got lat=%0d data=%h expected 2 1122334455667788", lat, mem_read_data);
    end
    $display("txn load+store request, load served data=%h", mem_read_data);
    release_req();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_aw_w_skew();
    test_misaligned();
    test_bresp_error_held();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
